load_exec: RTL and testbench

Load execution stage directly downstream of the AGU load address queue. It pops the head entry once its address is valid, issues a word read on the data-memory port, and waits for the response. It then presents the loaded word with destination register and ROB tag on a ready/valid writeback port. One load is in flight at a time; a flush aborts the current load and drains any orphaned memory response.

---
 rtl/load_exec.sv | 164 ++++++++++++++++
 tb/tb_load_exec.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_exec.sv
// load_exec: single-outstanding load execution stage between the AGU load queue and data memory.
// Optional response timeout is compiled in when LOAD_EXEC_TIMEOUT_EN is defined.
module load_exec #(
  parameter int WIDTH_REG  = 5,
  parameter int WIDTH_TAG  = 5,
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_DATA = 32,
  parameter int TIMEOUT_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_empty,
  input  logic                  i_A,
  input  logic                  i_val,
  input  logic [WIDTH_ADDR-1:0] i_addr,
  input  logic [WIDTH_REG-1:0]  i_rd,
  input  logic [WIDTH_TAG-1:0]  i_tag,
  output logic                  o_re,
  output logic                  o_mem_req,
  output logic [WIDTH_ADDR-1:0] o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [WIDTH_DATA-1:0] i_mem_rdata,
  output logic                  o_wb_val,
  output logic [WIDTH_REG-1:0]  o_wb_rd,
  output logic [WIDTH_TAG-1:0]  o_wb_tag,
  output logic [WIDTH_DATA-1:0] o_wb_data,
  output logic                  o_wb_err,
  input  logic                  i_wb_ready,
  input  logic                  i_flush,
  output logic                  o_busy
);

  // state    | meaning
  // ST_IDLE  | waiting for an allocated, address-valid head entry
  // ST_REQ   | read request presented, waiting for grant
  // ST_RESP  | request granted, waiting for read data
  // ST_WB    | result held on the writeback port until accepted
  // ST_DRAIN | flushed after grant; swallowing the orphaned response
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RESP  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  if (WIDTH_DATA != 32 || TIMEOUT_W < 1) begin : g_bad_param
    $error("load_exec: WIDTH_DATA must be 32 and TIMEOUT_W at least 1");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_mem_req;
  logic [WIDTH_ADDR-1:0] r_mem_addr;
  logic [WIDTH_REG-1:0]  r_wb_rd;
  logic [WIDTH_TAG-1:0]  r_wb_tag;
  logic [WIDTH_DATA-1:0] r_wb_data;
  logic                  r_wb_err;
  logic                  w_pop;
  logic                  w_aligned;
  logic                  w_take_rdata;
  logic                  w_take_tmo;
  logic                  w_tmo;

  assign w_aligned = (i_addr[1:0] == 2'b00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Flush outranks every other event; DRAIN keeps waiting for its response regardless.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_take_rdata = 1'b0;
    w_take_tmo   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_flush && !i_empty && i_A && i_val) begin
          w_pop       = 1'b1;
          w_state_nxt = w_aligned ? ST_REQ : ST_WB;
        end
      end
      ST_REQ: begin
        if (i_flush)        w_state_nxt = i_mem_gnt ? ST_DRAIN : ST_IDLE;
        else if (i_mem_gnt) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (i_flush) begin
          w_state_nxt = i_mem_rvalid ? ST_IDLE : ST_DRAIN;
        end else if (i_mem_rvalid) begin
          w_state_nxt  = ST_WB;
          w_take_rdata = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt = ST_WB;
          w_take_tmo  = 1'b1;
        end
      end
      ST_WB: begin
        if (i_flush || i_wb_ready) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (i_mem_rvalid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_wb_rd    <= '0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      r_mem_req <= (w_state_nxt == ST_REQ);
      if (w_pop) begin
        r_mem_addr <= i_addr;
        r_wb_rd    <= i_rd;
        r_wb_tag   <= i_tag;
        r_wb_data  <= '0;
        r_wb_err   <= ~w_aligned;
      end
      if (w_take_rdata) begin
        r_wb_data <= i_mem_rdata;
        r_wb_err  <= 1'b0;
      end
      if (w_take_tmo) begin
        r_wb_data <= '0;
        r_wb_err  <= 1'b1;
      end
    end
  end

`ifdef LOAD_EXEC_TIMEOUT_EN
  // Down-counter reloaded outside RESP; the 2^W-1'th silent RESP cycle is terminal.
  logic [TIMEOUT_W-1:0] r_tmo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_tmo <= '1;
    else if (r_state != ST_RESP) r_tmo <= '1;
    else if (!i_mem_rvalid)      r_tmo <= r_tmo - TIMEOUT_W'(1);
  end

  assign w_tmo = (r_state == ST_RESP) && (r_tmo == TIMEOUT_W'(1));
`else
  assign w_tmo = 1'b0;
`endif

  assign o_re       = w_pop;
  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_wb_val   = (r_state == ST_WB);
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_tag   = r_wb_tag;
  assign o_wb_data  = r_wb_data;
  assign o_wb_err   = r_wb_err;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_load_exec.sv
// Testbench for load_exec: vector table, directed corner sequences, and a randomized
// run scored against an in-order writeback stream derived from the queued entries.
module tb_load_exec;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_empty, i_A, i_val;
  logic [31:0] i_addr;
  logic [4:0]  i_rd, i_tag;
  logic        o_re, o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_val;
  logic [4:0]  o_wb_rd, o_wb_tag;
  logic [31:0] o_wb_data;
  logic        o_wb_err, i_wb_ready, i_flush, o_busy;

  int tests = 0;
  int fails = 0;

  load_exec dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_empty(i_empty), .i_A(i_A), .i_val(i_val),
    .i_addr(i_addr), .i_rd(i_rd), .i_tag(i_tag), .o_re(o_re), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_wb_val(o_wb_val), .o_wb_rd(o_wb_rd), .o_wb_tag(o_wb_tag),
    .o_wb_data(o_wb_data), .o_wb_err(o_wb_err), .i_wb_ready(i_wb_ready), .i_flush(i_flush),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        empty, a, val, flush;
    logic [31:0] addr;
    logic [4:0]  rd, tag;
    logic [31:0] rdata;
    logic        exp_re, exp_err;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct { logic [31:0] addr; logic [4:0] rd, tag; } ent_t;
  typedef struct { logic [4:0] rd, tag; logic [31:0] data; logic err; } wb_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  task automatic set_head(input logic e, input logic a, input logic v,
                          input logic [31:0] ad, input logic [4:0] rd, input logic [4:0] tg);
    i_empty = e; i_A = a; i_val = v; i_addr = ad; i_rd = rd; i_tag = tg;
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic run_vec(input vec_t v);
    cyc();
    set_head(v.empty, v.a, v.val, v.addr, v.rd, v.tag);
    i_flush = v.flush; i_mem_gnt = 0; i_mem_rvalid = 0; i_wb_ready = 0;
    smp();
    chk("vec_re", o_re, v.exp_re);
    cyc();
    set_head(1, 0, 0, 0, 0, 0); i_flush = 0;
    if (!v.exp_re) begin
      smp();
      chk("vec_no_pop_idle", o_busy, 0);
      return;
    end
    if (!v.exp_err) begin
      i_mem_gnt = 1;
      smp();
      chk("vec_req", o_mem_req, 1);
      chk("vec_req_addr", o_mem_addr, v.addr);
      cyc();
      i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = v.rdata;
      smp();
      chk("vec_resp_wbval", o_wb_val, 0);
      cyc();
      i_mem_rvalid = 0;
    end
    smp();
    chk("vec_wb_val", o_wb_val, 1);
    chk("vec_wb_rd", o_wb_rd, v.rd);
    chk("vec_wb_tag", o_wb_tag, v.tag);
    chk("vec_wb_data", o_wb_data, v.exp_data);
    chk("vec_wb_err", o_wb_err, v.exp_err);
    chk("vec_wb_noreq", o_mem_req, 0);
    i_wb_ready = 1;
    cyc();
    i_wb_ready = 0;
    smp();
    chk("vec_done_val", o_wb_val, 0);
    chk("vec_done_busy", o_busy, 0);
  endtask

  localparam int N_RND = 40;
  ent_t ents[N_RND];
  wb_t  sb[$];
  vec_t vecs[9];

  initial begin
    i_rst_n = 0; set_head(1, 0, 0, 0, 0, 0);
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0; i_wb_ready = 0; i_flush = 0;

    //          empty a val flush addr           rd  tag rdata          re err data
    vecs[0] = '{0, 1, 1, 0, 32'h0000_0100,  7,  3, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{1, 1, 1, 0, 32'h0000_0104,  1,  1, 32'h0,        0, 0, 32'h0};
    vecs[2] = '{0, 0, 1, 0, 32'h0000_0108,  1,  1, 32'h0,        0, 0, 32'h0};
    vecs[3] = '{0, 1, 0, 0, 32'h0000_010C,  1,  1, 32'h0,        0, 0, 32'h0};
    vecs[4] = '{0, 1, 1, 1, 32'h0000_0110,  1,  1, 32'h0,        0, 0, 32'h0};
    vecs[5] = '{0, 1, 1, 0, 32'h0000_0102,  2,  9, 32'h0,        1, 1, 32'h0};
    vecs[6] = '{0, 1, 1, 0, 32'h0000_0101,  3,  4, 32'h0,        1, 1, 32'h0};
    vecs[7] = '{0, 1, 1, 0, 32'h0000_0203, 30, 17, 32'h0,        1, 1, 32'h0};
    vecs[8] = '{0, 1, 1, 0, 32'hFFFF_FFFC, 31, 31, 32'h12345678, 1, 0, 32'h12345678};

    repeat (3) @(posedge i_clk);
    smp();
    chk("rst_busy", o_busy, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_wbval", o_wb_val, 0);
    chk("rst_wberr", o_wb_err, 0);
    chk("rst_re", o_re, 0);
    i_rst_n = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset in the middle of RESP
    cyc(); set_head(0, 1, 1, 32'h400, 1, 1); smp(); chk("mrst_pop", o_re, 1);
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_mem_gnt = 1; smp(); chk("mrst_req", o_mem_req, 1);
    cyc(); i_mem_gnt = 0; smp(); chk("mrst_resp_busy", o_busy, 1);
    i_rst_n = 0;
    cyc();
    chk("mrst_busy", o_busy, 0); chk("mrst_req0", o_mem_req, 0);
    chk("mrst_wbval", o_wb_val, 0); chk("mrst_re", o_re, 0);
    smp(); i_rst_n = 1;

    // writeback backpressure with the next head waiting
    cyc(); set_head(0, 1, 1, 32'h200, 4, 5); smp(); chk("bp_pop", o_re, 1);
    cyc(); set_head(0, 1, 1, 32'h204, 6, 8); i_mem_gnt = 1; smp(); chk("bp_req", o_mem_req, 1); chk("bp_re_req", o_re, 0);
    cyc(); i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D; smp(); chk("bp_re_resp", o_re, 0);
    cyc(); i_mem_rvalid = 0; i_wb_ready = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_val", o_wb_val, 1); chk("bp_data", o_wb_data, 32'hCAFEF00D);
      chk("bp_rd", o_wb_rd, 4); chk("bp_tag", o_wb_tag, 5);
      chk("bp_err", o_wb_err, 0); chk("bp_re_hold", o_re, 0);
      cyc();
    end
    i_wb_ready = 1; smp(); chk("bp_hs_val", o_wb_val, 1); chk("bp_hs_re", o_re, 0);
    cyc(); i_wb_ready = 0; smp(); chk("bp_next_pop", o_re, 1); chk("bp_next_val", o_wb_val, 0);
    // flush in REQ without grant
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_flush = 1; smp();
    chk("freq_req", o_mem_req, 1); chk("freq_addr", o_mem_addr, 32'h204);
    cyc(); i_flush = 0; smp(); chk("freq_req0", o_mem_req, 0); chk("freq_idle", o_busy, 0);

    // flush in RESP, response three cycles later
    cyc(); set_head(0, 1, 1, 32'h300, 9, 10); smp(); chk("fresp_pop", o_re, 1);
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_mem_gnt = 1; smp();
    cyc(); i_mem_gnt = 0; i_flush = 1; smp(); chk("fresp_busy", o_busy, 1);
    cyc(); i_flush = 0; set_head(0, 1, 1, 32'h301, 11, 12); smp();
    chk("drain1_re", o_re, 0); chk("drain1_busy", o_busy, 1);
    cyc(); smp(); chk("drain2_re", o_re, 0);
    cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'h11111111; smp();
    chk("drain3_re", o_re, 0); chk("drain3_val", o_wb_val, 0);
    cyc(); i_mem_rvalid = 0; smp(); chk("drain_after_pop", o_re, 1); chk("drain_after_val", o_wb_val, 0);
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_wb_ready = 1; smp();
    chk("drain_next_val", o_wb_val, 1); chk("drain_next_err", o_wb_err, 1);
    chk("drain_next_data", o_wb_data, 0); chk("drain_next_rd", o_wb_rd, 11);
    chk("drain_next_tag", o_wb_tag, 12); chk("drain_next_noreq", o_mem_req, 0);
    cyc(); i_wb_ready = 0; smp(); chk("drain_next_idle", o_busy, 0);

    // flush in REQ together with grant
    cyc(); set_head(0, 1, 1, 32'h500, 1, 2); smp(); chk("fgnt_pop", o_re, 1);
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_mem_gnt = 1; i_flush = 1; smp(); chk("fgnt_req", o_mem_req, 1);
    cyc(); i_mem_gnt = 0; i_flush = 0; smp(); chk("fgnt_drain", o_busy, 1); chk("fgnt_req0", o_mem_req, 0);
    cyc(); smp(); chk("fgnt_wait", o_busy, 1);
    cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'h22222222; smp();
    cyc(); i_mem_rvalid = 0; smp(); chk("fgnt_idle", o_busy, 0); chk("fgnt_noval", o_wb_val, 0);

    // flush in WB
    cyc(); set_head(0, 1, 1, 32'h601, 3, 4); i_wb_ready = 0; smp(); chk("fwb_pop", o_re, 1);
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_flush = 1; smp(); chk("fwb_val", o_wb_val, 1);
    cyc(); i_flush = 0; smp(); chk("fwb_val0", o_wb_val, 0); chk("fwb_idle", o_busy, 0);

    // flush in RESP coinciding with read data
    cyc(); set_head(0, 1, 1, 32'h700, 5, 6); smp(); chk("frv_pop", o_re, 1);
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_mem_gnt = 1; smp();
    cyc(); i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h33333333; i_flush = 1; smp();
    cyc(); i_mem_rvalid = 0; i_flush = 0; smp(); chk("frv_idle", o_busy, 0); chk("frv_noval", o_wb_val, 0);

    // long response wait
    cyc(); set_head(0, 1, 1, 32'h800, 13, 14); i_wb_ready = 0; smp(); chk("tmo_pop", o_re, 1);
    cyc(); set_head(1, 0, 0, 0, 0, 0); i_mem_gnt = 1; smp();
    cyc(); i_mem_gnt = 0;
`ifdef LOAD_EXEC_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      smp(); chk("tmo_wait_val", o_wb_val, 0); chk("tmo_wait_busy", o_busy, 1);
      cyc();
    end
    smp();
    chk("tmo_val", o_wb_val, 1); chk("tmo_err", o_wb_err, 1); chk("tmo_data", o_wb_data, 0);
    chk("tmo_rd", o_wb_rd, 13); chk("tmo_tag", o_wb_tag, 14);
    cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'hBAD0BAD0; smp();
    chk("tmo_late_data", o_wb_data, 0); chk("tmo_late_err", o_wb_err, 1);
    cyc(); i_mem_rvalid = 0; i_wb_ready = 1; smp();
    cyc(); i_wb_ready = 0; smp(); chk("tmo_idle", o_busy, 0); chk("tmo_val0", o_wb_val, 0);
`else
    for (int i = 0; i < 20; i++) begin
      smp(); chk("wait_val", o_wb_val, 0); chk("wait_busy", o_busy, 1);
      cyc();
    end
    i_mem_rvalid = 1; i_mem_rdata = 32'h0BADF00D; smp();
    cyc(); i_mem_rvalid = 0; i_wb_ready = 1; smp();
    chk("wait_val1", o_wb_val, 1); chk("wait_data", o_wb_data, 32'h0BADF00D); chk("wait_err", o_wb_err, 0);
    cyc(); i_wb_ready = 0; smp(); chk("wait_idle", o_busy, 0);
`endif

    // randomized run against the in-order expected writeback stream
    begin
      int h;
      logic pend, head_ok, hold, cur_aligned;
      int pend_dly;
      logic [31:0] cur_addr;
      wb_t prev, exp_wb;

      for (int i = 0; i < N_RND; i++) begin
        ents[i].addr = $urandom;
        if ($urandom_range(0, 3) != 0) ents[i].addr[1:0] = 2'b00;
        ents[i].rd  = 5'($urandom);
        ents[i].tag = 5'($urandom);
      end
      h = 0; pend = 0; pend_dly = 0; hold = 0; cur_aligned = 0; cur_addr = 0;
      prev = '{0, 0, 0, 0};
      for (int c = 0; c < 4000 && !(h == N_RND && sb.size() == 0); c++) begin
        cyc();
        i_mem_rvalid = 0; i_mem_rdata = $urandom;
        if (pend) begin
          if (pend_dly == 0) begin
            i_mem_rvalid = 1; i_mem_rdata = mem_f(cur_addr); pend = 0;
          end else pend_dly--;
        end else if ($urandom_range(0, 3) == 0) i_mem_rvalid = 1;
        i_mem_gnt  = 1'($urandom_range(0, 1));
        i_wb_ready = ($urandom_range(0, 2) != 0);
        if (h < N_RND && $urandom_range(0, 3) != 0)
          set_head(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
                   ents[h].addr, ents[h].rd, ents[h].tag);
        else
          set_head(1, 1'($urandom), 1'($urandom), $urandom, 5'($urandom), 5'($urandom));
        head_ok = !i_empty && i_A && i_val;
        smp();
        if (o_re) begin
          chk("rnd_re_head_valid", head_ok, 1);
          chk("rnd_re_one_in_flight", sb.size(), 0);
          cur_addr = ents[h].addr;
          cur_aligned = (cur_addr[1:0] == 2'b00);
          exp_wb.rd = ents[h].rd; exp_wb.tag = ents[h].tag;
          exp_wb.err = !cur_aligned;
          exp_wb.data = cur_aligned ? mem_f(cur_addr) : 32'h0;
          sb.push_back(exp_wb);
          h++;
        end else begin
          if (sb.size() != 0 && !cur_aligned) chk("rnd_no_req_misaligned", o_mem_req, 0);
          if (o_mem_req && i_mem_gnt) begin
            chk("rnd_req_addr", o_mem_addr, cur_addr);
            pend = 1; pend_dly = $urandom_range(0, 3);
          end
        end
        if (hold) begin
          chk("rnd_wb_held", o_wb_val, 1);
          chk("rnd_wb_stable_data", o_wb_data, prev.data);
          chk("rnd_wb_stable_id", {o_wb_rd, o_wb_tag}, {prev.rd, prev.tag});
        end
        hold = 0;
        if (o_wb_val) begin
          if (sb.size() == 0) chk("rnd_wb_unexpected", o_wb_val, 0);
          else if (i_wb_ready) begin
            exp_wb = sb.pop_front();
            chk("rnd_wb_rd", o_wb_rd, exp_wb.rd);
            chk("rnd_wb_tag", o_wb_tag, exp_wb.tag);
            chk("rnd_wb_data", o_wb_data, exp_wb.data);
            chk("rnd_wb_err", o_wb_err, exp_wb.err);
          end else begin
            hold = 1;
            prev.rd = o_wb_rd; prev.tag = o_wb_tag; prev.data = o_wb_data; prev.err = o_wb_err;
          end
        end
      end
      chk("rnd_all_popped", h, N_RND);
      chk("rnd_all_written_back", sb.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
